// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//
// Multi-cycle adder/subtractor. Operands are processed CHUNK bits per clock;
// the carry between chunks is kept in a register, so one narrow adder serves
// a WIDTH-bit datapath. The result is WIDTH bits of sum/difference plus carry
// (or borrow), signed overflow, zero and negative flags.
//
// Operations (op):
//   2'b00 ADD  a + b
//   2'b01 SUB  a - b
//   2'b10 ADC  a + b + cin
//   2'b11 SBC  a - b - cin
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits processed per cycle (1 <= CHUNK <= WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   operand set valid
//   in_ready   block is idle and accepts operands
//   a, b       operands
//   op         operation select (see above)
//   cin        carry/borrow in, used only by ADC/SBC
//   out_valid  result valid; held until out_ready
//   out_ready  consumer takes the result
//   s          result bits [WIDTH-1:0]
//   c_out      carry (add ops) or borrow (sub ops, 1 = a < b+cin unsigned)
//   ovf        signed overflow (before any saturation)
//   zero       s == 0
//   neg        s[WIDTH-1]
//   sat        saturate on signed overflow (only with ADDSUB_SAT_EN)
//
// Build option:
//   ADDSUB_SAT_EN  when defined, adds the sat input and clamps s to the most
//                  positive / most negative value on signed overflow. When
//                  undefined, s is always the wrapped result.
//
// Latency: operands accepted at edge t give out_valid after edge t+N,
// N = WIDTH/CHUNK. One further cycle is spent on the DONE->IDLE handoff.
// -----------------------------------------------------------------------------
module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             zero,
   output logic             neg
`ifdef ADDSUB_SAT_EN
   ,
   input  logic             sat
`endif
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   k_q, k_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   // b is stored already conditioned (inverted for sub ops), so the chunk
   // adder only ever adds.
   logic [WIDTH-1:0]   bp_q, bp_d;
   logic               sub_q, sub_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               out_valid_q, out_valid_d;
`ifdef ADDSUB_SAT_EN
   logic               sat_q, sat_d;
`endif

   // ---------------------------------------------------------------------------
   // Chunk slicing of the latched operands
   // ---------------------------------------------------------------------------
   logic [CHUNK-1:0] a_chunk  [N];
   logic [CHUNK-1:0] bp_chunk [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_chunk[gi]  = a_q[gi*CHUNK +: CHUNK];
      assign bp_chunk[gi] = bp_q[gi*CHUNK +: CHUNK];
   end

   // Select the chunk addressed by k_q. Written as a compare-mux so the index
   // width never has to match the array size (N need not be a power of two).
   logic [CHUNK-1:0] a_cur;
   logic [CHUNK-1:0] bp_cur;

   always_comb begin
      a_cur  = '0;
      bp_cur = '0;
      for (int i = 0; i < N; i++) begin
         if (k_q == IDX_W'(i)) begin
            a_cur  = a_chunk[i];
            bp_cur = bp_chunk[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Chunk adder and final-chunk flag logic
   // ---------------------------------------------------------------------------
   logic [CHUNK:0]   sum_ext;
   logic             last_chunk;
   logic             raw_c;
   logic             ovf_fin;
   logic [WIDTH-1:0] s_wrap;
   logic [WIDTH-1:0] s_fin;

   assign sum_ext    = {1'b0, a_cur} + {1'b0, bp_cur} + {{CHUNK{1'b0}}, carry_q};
   assign last_chunk = (k_q == LAST_K);
   assign raw_c      = sum_ext[CHUNK];

   // On the last chunk, a_cur/bp_cur/sum_ext MSBs are the word MSBs.
   assign ovf_fin = (a_cur[CHUNK-1] == bp_cur[CHUNK-1]) &&
                    (sum_ext[CHUNK-1] != a_cur[CHUNK-1]);

   // s with the current chunk merged in.
   always_comb begin
      s_wrap = s_q;
      for (int i = 0; i < N; i++) begin
         if (k_q == IDX_W'(i)) begin
            s_wrap[i*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
         end
      end
   end

`ifdef ADDSUB_SAT_EN
   // On overflow the true result has the sign of a, so clamp towards it.
   always_comb begin
      s_fin = s_wrap;
      if (sat_q && ovf_fin) begin
         if (a_q[WIDTH-1]) begin
            s_fin = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            s_fin = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end
   end
`else
   assign s_fin = s_wrap;
`endif

   // ---------------------------------------------------------------------------
   // FSM next-state and datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      carry_d     = carry_q;
      a_d         = a_q;
      bp_d        = bp_q;
      sub_d       = sub_q;
      s_d         = s_q;
      c_out_d     = c_out_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      out_valid_d = out_valid_q;
`ifdef ADDSUB_SAT_EN
      sat_d       = sat_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d   = a;
               sub_d = op[0];
               bp_d  = op[0] ? ~b : b;
               // Carry seed: 0 ADD, 1 SUB (two's complement +1),
               // cin ADC, ~cin SBC (a + ~b + 1 - cin = a - b - cin).
               unique case (op)
                  2'b00:   carry_d = 1'b0;
                  2'b01:   carry_d = 1'b1;
                  2'b10:   carry_d = cin;
                  default: carry_d = ~cin;
               endcase
`ifdef ADDSUB_SAT_EN
               sat_d   = sat;
`endif
               k_d     = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            carry_d = raw_c;
            if (last_chunk) begin
               s_d         = s_fin;
               c_out_d     = raw_c ^ sub_q;   // borrow is the inverted carry
               ovf_d       = ovf_fin;
               zero_d      = (s_fin == '0);
               neg_d       = s_fin[WIDTH-1];
               out_valid_d = 1'b1;
               k_d         = '0;
               state_d     = S_DONE;
            end else begin
               s_d = s_wrap;
               k_d = k_q + IDX_W'(1);
            end
         end

         S_DONE: begin
            // Outputs frozen until the consumer takes the result; no new
            // operand is accepted in the handoff cycle.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         bp_q        <= '0;
         sub_q       <= 1'b0;
         s_q         <= '0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ADDSUB_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         bp_q        <= bp_d;
         sub_q       <= sub_d;
         s_q         <= s_d;
         c_out_q     <= c_out_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
`ifdef ADDSUB_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule
